// File: rtl/siphash_stream_core.sv
// siphash_stream_core: streaming SipHash-c-d engine with automatic padding (SIPHASH_LONG_EN adds SipHash-128 output).
// Latency: init->mi_ready 2 cycles; 2+ceil(c/R) per block; finalisation 1+ceil(d/R) (twice in 128-bit mode).
// Backpressure: mi_ready is high only in WAIT and drops on accept until the block has been absorbed.
module siphash_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int RND_W            = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init,
  input  logic             long,
  input  logic [RND_W-1:0] c,
  input  logic [RND_W-1:0] d,
  input  logic [127:0]     k,
  input  logic [63:0]      mi,
  input  logic             mi_valid,
  input  logic             mi_last,
  input  logic [3:0]       mi_bytes,
  output logic             mi_ready,
  output logic             ready,
  output logic [127:0]     hash_word,
  output logic             hash_valid
);

  typedef struct packed {
    logic [63:0] v0;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [63:0] v3;
  } sip_t;

  typedef enum logic [3:0] {
    IDLE, LOAD, WAIT, COMP, CEND, PAD, FXOR, FIN, FXOR2, FIN2
  } state_t;

  function automatic sip_t sip_round(input sip_t s);
    sip_t r;
    r    = s;
    r.v0 = r.v0 + r.v1;
    r.v1 = {r.v1[50:0], r.v1[63:51]} ^ r.v0;
    r.v0 = {r.v0[31:0], r.v0[63:32]};
    r.v2 = r.v2 + r.v3;
    r.v3 = {r.v3[47:0], r.v3[63:48]} ^ r.v2;
    r.v0 = r.v0 + r.v3;
    r.v3 = {r.v3[42:0], r.v3[63:43]} ^ r.v0;
    r.v2 = r.v2 + r.v1;
    r.v1 = {r.v1[46:0], r.v1[63:47]} ^ r.v2;
    r.v2 = {r.v2[31:0], r.v2[63:32]};
    return r;
  endfunction

  function automatic logic [63:0] fold(input sip_t s);
    return s.v0 ^ s.v1 ^ s.v2 ^ s.v3;
  endfunction

  state_t           state;
  sip_t             v;
  logic [63:0]      m;
  logic [7:0]       len;
  logic [RND_W-1:0] cnt;
  logic [RND_W-1:0] c_q;
  logic [RND_W-1:0] d_q;
  logic             long_q;
  logic             pad_pend;
  logic             last_blk;
  logic [63:0]      hash_lo;

  logic long_in;
`ifdef SIPHASH_LONG_EN
  logic [63:0] hash_hi;
  assign long_in   = long;
  assign hash_word = {hash_hi, hash_lo};
`else
  logic unused_long;
  assign unused_long = long;
  assign long_in     = 1'b0;
  assign hash_word   = {64'h0, hash_lo};
`endif

  sip_t        v_r1, v_r2, v_step, v_fx;
  logic        cnt_last;
  logic        fin1_done;
  logic [63:0] fold_val;
  logic [3:0]  nbytes;
  logic [63:0] m_acc;
  logic [7:0]  len_acc;

  always_comb begin
    v_r1     = sip_round(v);
    v_r2     = sip_round(v_r1);
    // a lone trailing round in 2-per-cycle mode uses the first stage only
    v_step   = (ROUNDS_PER_CYCLE == 2 && cnt > RND_W'(1)) ? v_r2 : v_r1;
    cnt_last = (cnt <= RND_W'(ROUNDS_PER_CYCLE));
    v_fx     = v;
    if (state == FXOR2) v_fx.v1 = v.v1 ^ 64'hdd;
    else                v_fx.v2 = v.v2 ^ (long_q ? 64'hee : 64'hff);
    fold_val  = (state == FXOR || state == FXOR2) ? fold(v_fx) : fold(v_step);
    fin1_done = (state == FXOR && d_q == '0) || (state == FIN && cnt_last);
    nbytes    = (mi_bytes > 4'd8) ? 4'd8 : mi_bytes;
    m_acc     = mi;
    if (mi_last && nbytes != 4'd8) begin
      for (int i = 0; i < 7; i++)
        if (4'(i) >= nbytes) m_acc[8*i +: 8] = 8'h00;
      m_acc[63:56] = len + {4'h0, nbytes};
    end
    len_acc = len + (mi_last ? {4'h0, nbytes} : 8'd8);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      v          <= '0;
      m          <= '0;
      len        <= '0;
      cnt        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      long_q     <= 1'b0;
      pad_pend   <= 1'b0;
      last_blk   <= 1'b0;
      hash_lo    <= '0;
`ifdef SIPHASH_LONG_EN
      hash_hi    <= '0;
`endif
      mi_ready   <= 1'b0;
      ready      <= 1'b1;
      hash_valid <= 1'b0;
    end else if (init && (state == IDLE || state == WAIT)) begin
      v.v0       <= k[63:0]   ^ 64'h736f6d6570736575;
      v.v1       <= k[127:64] ^ 64'h646f72616e646f6d ^ (long_in ? 64'hee : 64'h0);
      v.v2       <= k[63:0]   ^ 64'h6c7967656e657261;
      v.v3       <= k[127:64] ^ 64'h7465646279746573;
      len        <= '0;
      c_q        <= c;
      d_q        <= d;
      long_q     <= long_in;
      pad_pend   <= 1'b0;
      last_blk   <= 1'b0;
      hash_lo    <= '0;
`ifdef SIPHASH_LONG_EN
      hash_hi    <= '0;
`endif
      hash_valid <= 1'b0;
      mi_ready   <= 1'b0;
      ready      <= 1'b0;
      state      <= LOAD;
    end else begin
      case (state)
        LOAD: begin
          mi_ready <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (mi_valid && mi_ready) begin
            m        <= m_acc;
            v.v3     <= v.v3 ^ m_acc;
            len      <= len_acc;
            last_blk <= mi_last;
            pad_pend <= mi_last && nbytes == 4'd8;
            mi_ready <= 1'b0;
            cnt      <= c_q;
            state    <= (c_q == '0) ? CEND : COMP;
          end
        end
        COMP: begin
          v   <= v_step;
          cnt <= cnt - RND_W'(ROUNDS_PER_CYCLE);
          if (cnt_last) state <= CEND;
        end
        CEND: begin
          v.v0 <= v.v0 ^ m;
          if (pad_pend) state <= PAD;
          else if (last_blk) state <= FXOR;
          else begin
            mi_ready <= 1'b1;
            state    <= WAIT;
          end
        end
        PAD: begin
          // full final word: the length byte travels in its own block
          m        <= {len, 56'h0};
          v.v3     <= v.v3 ^ {len, 56'h0};
          pad_pend <= 1'b0;
          cnt      <= c_q;
          state    <= (c_q == '0) ? CEND : COMP;
        end
        FXOR: begin
          v     <= v_fx;
          cnt   <= d_q;
          state <= FIN;
        end
        FIN: begin
          v   <= v_step;
          cnt <= cnt - RND_W'(ROUNDS_PER_CYCLE);
        end
`ifdef SIPHASH_LONG_EN
        FXOR2: begin
          v     <= v_fx;
          cnt   <= d_q;
          state <= FIN2;
        end
        FIN2: begin
          v   <= v_step;
          cnt <= cnt - RND_W'(ROUNDS_PER_CYCLE);
        end
`endif
        default: state <= IDLE;
      endcase

      if (fin1_done) begin
        hash_lo <= fold_val;
`ifdef SIPHASH_LONG_EN
        if (long_q) state <= FXOR2;
        else begin
          hash_valid <= 1'b1;
          ready      <= 1'b1;
          state      <= IDLE;
        end
`else
        hash_valid <= 1'b1;
        ready      <= 1'b1;
        state      <= IDLE;
`endif
      end

`ifdef SIPHASH_LONG_EN
      if ((state == FXOR2 && d_q == '0) || (state == FIN2 && cnt_last)) begin
        hash_hi    <= fold_val;
        hash_valid <= 1'b1;
        ready      <= 1'b1;
        state      <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_siphash_stream_core.sv
// Bench for siphash_stream_core: one instance per unroll factor, checked against a byte-level SipHash model.
module tb_siphash_stream_core;

  localparam int RND_W = 4;
`ifdef SIPHASH_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  localparam logic [127:0] KEY = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic             init       [2];
  logic             long_i     [2];
  logic [RND_W-1:0] c_i        [2];
  logic [RND_W-1:0] d_i        [2];
  logic [127:0]     k_i        [2];
  logic [63:0]      mi         [2];
  logic             mi_valid   [2];
  logic             mi_last    [2];
  logic [3:0]       mi_bytes   [2];
  logic             mi_ready   [2];
  logic             ready      [2];
  logic [127:0]     hash_word  [2];
  logic             hash_valid [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    siphash_stream_core #(.ROUNDS_PER_CYCLE(g + 1), .RND_W(RND_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .init       (init[g]),
      .long       (long_i[g]),
      .c          (c_i[g]),
      .d          (d_i[g]),
      .k          (k_i[g]),
      .mi         (mi[g]),
      .mi_valid   (mi_valid[g]),
      .mi_last    (mi_last[g]),
      .mi_bytes   (mi_bytes[g]),
      .mi_ready   (mi_ready[g]),
      .ready      (ready[g]),
      .hash_word  (hash_word[g]),
      .hash_valid (hash_valid[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [255:0] sip_rounds(input logic [255:0] s, input int n);
    logic [63:0] v0, v1, v2, v3;
    {v0, v1, v2, v3} = s;
    for (int i = 0; i < n; i++) begin
      v0 += v1; v1 = rotl(v1, 13); v1 ^= v0; v0 = rotl(v0, 32);
      v2 += v3; v3 = rotl(v3, 16); v3 ^= v2;
      v0 += v3; v3 = rotl(v3, 21); v3 ^= v0;
      v2 += v1; v1 = rotl(v1, 17); v1 ^= v2; v2 = rotl(v2, 32);
    end
    return {v0, v1, v2, v3};
  endfunction

  function automatic logic [127:0] ref_hash(input logic [127:0] key, input logic [7:0] msg[$],
                                            input int c, input int d, input bit lng);
    logic [63:0] v0, v1, v2, v3, m, lo, hi;
    int n;
    n  = msg.size();
    v0 = key[63:0]   ^ 64'h736f6d6570736575;
    v1 = key[127:64] ^ 64'h646f72616e646f6d;
    v2 = key[63:0]   ^ 64'h6c7967656e657261;
    v3 = key[127:64] ^ 64'h7465646279746573;
    if (lng) v1 ^= 64'hee;
    for (int b = 0; b <= n / 8; b++) begin
      m = '0;
      for (int j = 0; j < 8; j++)
        if (b * 8 + j < n) m[8*j +: 8] = msg[b * 8 + j];
      if (b == n / 8) m[63:56] = 8'(n);
      v3 ^= m;
      {v0, v1, v2, v3} = sip_rounds({v0, v1, v2, v3}, c);
      v0 ^= m;
    end
    v2 ^= lng ? 64'hee : 64'hff;
    {v0, v1, v2, v3} = sip_rounds({v0, v1, v2, v3}, d);
    lo = v0 ^ v1 ^ v2 ^ v3;
    hi = '0;
    if (lng) begin
      v1 ^= 64'hdd;
      {v0, v1, v2, v3} = sip_rounds({v0, v1, v2, v3}, d);
      hi = v0 ^ v1 ^ v2 ^ v3;
    end
    return {hi, lo};
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic do_init(input int u, input logic [127:0] key, input int c, input int d,
                         input bit lng, input bit collide);
    int lat;
    if (collide) begin
      // throwaway hash; restart it while a word is offered in the same cycle
      @(negedge clk);
      init[u] = 1'b1; k_i[u] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      init[u] = 1'b0;
      lat = 0;
      while (!mi_ready[u] && lat < 20) begin @(negedge clk); lat++; end
      mi[u] = {$urandom, $urandom}; mi_last[u] = 1'b1; mi_bytes[u] = 4'd3; mi_valid[u] = 1'b1;
    end else begin
      @(negedge clk);
    end
    init[u] = 1'b1; k_i[u] = key; c_i[u] = RND_W'(c); d_i[u] = RND_W'(d); long_i[u] = lng;
    @(negedge clk);
    init[u] = 1'b0; mi_valid[u] = 1'b0;
    c_i[u] = RND_W'($urandom); d_i[u] = RND_W'($urandom); long_i[u] = 1'($urandom);
    check("hv_cleared", hash_valid[u], 1'b0);
    lat = 1;
    while (!mi_ready[u] && lat < 20) begin @(negedge clk); lat++; end
    check("init_to_mi_ready", lat, 2);
  endtask

  task automatic send_word(input int u, input logic [63:0] w, input bit last, input logic [3:0] bytes,
                           input int exp_lat, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    mi[u] = w; mi_last[u] = last; mi_bytes[u] = bytes; mi_valid[u] = 1'b1;
    t = 0;
    while (!mi_ready[u] && t < 200) begin @(negedge clk); t++; end
    check("accept_ready", mi_ready[u], 1'b1);
    @(negedge clk);
    mi_valid[u] = 1'b0; mi[u] = {$urandom, $urandom}; mi_bytes[u] = 4'($urandom);
    if (!last) begin
      t = 1;
      while (!mi_ready[u] && t < 200) begin @(negedge clk); t++; end
      check("block_latency", t, exp_lat);
    end
  endtask

  task automatic wait_hash(input int u, input logic [127:0] exp, input int exp_lat);
    int lat;
    bit low_ok;
    lat = 1; low_ok = 1'b1;
    while (!hash_valid[u] && lat < 500) begin
      if (mi_ready[u] || ready[u]) low_ok = 1'b0;
      @(negedge clk); lat++;
    end
    check("busy_until_done", low_ok, 1'b1);
    check("done_latency", lat, exp_lat);
    check("hash_word", hash_word[u], exp);
    check("ready_done", ready[u], 1'b1);
  endtask

  task automatic run_msg(input int u, input logic [127:0] key, input int c, input int d, input bit lng,
                         input int nfull, input int lb, input bit pattern, input bit collide);
    logic [7:0]   msg[$];
    logic [63:0]  w;
    logic [127:0] exp;
    int r, cc, dd, nb, bf, exp_lat;
    bit le;
    r  = u + 1;
    cc = (c + r - 1) / r;
    dd = (d + r - 1) / r;
    le = lng && LONG_EN;
    do_init(u, key, c, d, lng, collide);
    for (int i = 0; i <= nfull; i++) begin
      w  = {$urandom, $urandom};
      nb = (i == nfull) ? lb : 8;
      for (int j = 0; j < nb; j++) begin
        if (pattern) w[8*j +: 8] = 8'(8 * i + j);
        msg.push_back(w[8*j +: 8]);
      end
      if (i == nfull) begin
        bf = (lb == 8 && $urandom_range(0, 1) == 1) ? int'($urandom_range(9, 15)) : lb;
        send_word(u, w, 1'b1, 4'(bf), 0, $urandom_range(0, 2));
      end else begin
        send_word(u, w, 1'b0, 4'd8, cc + 2, $urandom_range(0, 2));
      end
    end
    exp     = ref_hash(key, msg, c, d, le);
    exp_lat = cc + 1 + ((lb == 8) ? cc + 2 : 0) + 1 + dd + (le ? 1 + dd : 0) + 1;
    wait_hash(u, exp, exp_lat);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      init[u] = 1'b0; long_i[u] = 1'b0; c_i[u] = '0; d_i[u] = '0; k_i[u] = '0;
      mi[u] = '0; mi_valid[u] = 1'b0; mi_last[u] = 1'b0; mi_bytes[u] = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", ready[u], 1'b1);
      check("rst_mi_ready", mi_ready[u], 1'b0);
      check("rst_hash_valid", hash_valid[u], 1'b0);
      check("rst_hash_word", hash_word[u], '0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int u = 0; u < 2; u++) begin
      run_msg(u, KEY, 2, 4, 1'b0, 1, 7, 1'b1, 1'b0);
      check("kat_2_4_15B", hash_word[u], {64'h0, 64'ha129ca6149be45e5});
      run_msg(u, KEY, 2, 4, 1'b0, 0, 0, 1'b0, 1'b0);
      check("kat_empty", hash_word[u], {64'h0, 64'h726fdb47dd0e0e31});
      run_msg(u, KEY, 2, 4, 1'b1, 0, 0, 1'b0, 1'b0);
      check("kat_long_empty", hash_word[u],
            LONG_EN ? {64'h930255c71472f66d, 64'he6a825ba047f81a3} : {64'h0, 64'h726fdb47dd0e0e31});
      run_msg(u, KEY, 2, 4, 1'b0, 0, 8, 1'b1, 1'b0);
      run_msg(u, KEY, 3, 4, 1'b0, 1, 7, 1'b1, 1'b0);
      run_msg(u, KEY, 3, 3, 1'b1, 0, 8, 1'b1, 1'b0);
      run_msg(u, KEY, 2, 4, 1'b0, 2, 5, 1'b1, 1'b1);
      repeat (20)
        run_msg(u, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 8), 1'b0,
                $urandom_range(0, 3) == 0);
    end

    // length byte wraps past 255
    run_msg(0, KEY, 1, 2, 1'b0, 33, 3, 1'b1, 1'b0);

    // reset while finalising
    do_init(0, KEY, 2, 4, 1'b0, 1'b0);
    send_word(0, 64'h0, 1'b1, 4'd0, 0, 0);
    repeat (4) @(negedge clk);
    check("busy_in_fin", ready[0], 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", ready[0], 1'b1);
    check("midrst_hash_valid", hash_valid[0], 1'b0);
    check("midrst_mi_ready", mi_ready[0], 1'b0);
    check("midrst_hash_word", hash_word[0], '0);
    reset_n = 1'b1;
    run_msg(0, KEY, 2, 4, 1'b0, 0, 0, 1'b0, 1'b0);
    check("post_rst_kat", hash_word[0], {64'h0, 64'h726fdb47dd0e0e31});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/siphash_stream_core.md
# siphash_stream_core

Parametrised SipHash engine that accepts a message as a stream of 64-bit words with a valid/ready handshake. It pads the final block and produces a 64-bit (SipHash-c-d) or 128-bit (SipHash-128) tag. It sits where the single-block core sits today. It adds automatic length/padding handling, runtime round counts, optional 2-rounds-per-cycle unrolling, and 128-bit output mode.

## Interface

Parameters:
- ROUNDS_PER_CYCLE, 1, SipRounds executed per cycle; legal values are 1 or 2 (2 = two chained SipRounds).
- RND_W, 4, width of the c and d inputs.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- init  in  1  single-cycle pulse. Loads the key and starts a new hash.
- long  in  1  selects 128-bit output when 1. Sampled on init.
- c  in  RND_W  compression rounds. Sampled on init.
- d  in  RND_W  finalization rounds. Sampled on init.
- k  in  128  key. k[63:0]=k0, k[127:64]=k1.
- mi  in  64  message word, little-endian bytes (byte 0 = mi[7:0]).
- mi_valid  in  1  word present.
- mi_last  in  1  marks the final word.
- mi_bytes  in  4  valid bytes in the last word, 0..8. Values >8 are treated as 8. Ignored unless mi_last is set.
- mi_ready  out  1  core can accept a word.
- ready  out  1  core idle (no hash in progress).
- hash_word  out  128  tag. Short mode: [63:0] holds the tag, [127:64]=0. Long mode: [63:0]=first half, [127:64]=second half.
- hash_valid  out  1  tag valid.

## Operation

- Reset values: v0..v3=0, len=0, mi_ready=0, ready=1, hash_valid=0, hash_word=0, state IDLE.
- States: IDLE, LOAD, WAIT, COMP, CEND, PAD, FXOR, FIN, FXOR2, FIN2.
- IDLE/WAIT + init goes to LOAD:
  - v0=k0^736f6d6570736575, v1=k1^646f72616e646f6d, v2=k0^6c7967656e657261, v3=k1^7465646279746573.
  - Long mode additionally applies v1^=0xee.
  - len=0; hash_valid cleared; c, d and long latched.
  - Next state WAIT.
- WAIT: mi_ready=1. On mi_valid&&mi_ready the core latches block m and applies v3^=m.
  - Non-last word: m=mi; len+=8 (mod 256).
  - Last word, mi_bytes<8: m = {len+mi_bytes, mi with bytes ≥ mi_bytes zeroed}.
  - Last word, mi_bytes=8: m=mi, len+=8, and a pad block is flagged.
- COMP: ceil(c/ROUNDS_PER_CYCLE) cycles. With ROUNDS_PER_CYCLE=2 and odd c, the final cycle runs one round. c=0 gives zero COMP cycles.
- CEND: v0^=m. Then:
  - pad flagged: go to PAD, where m={len,56'h0} and v3^=m, then COMP and CEND again.
  - last block done: go to FXOR.
  - otherwise: go to WAIT.
- FXOR: v2^=0xff in short mode, v2^=0xee in long mode. Then FIN runs ceil(d/ROUNDS_PER_CYCLE) cycles.
  - End of FIN, short mode: hash_word[63:0]=v0^v1^v2^v3.
  - End of FIN, long mode: the same value goes into [63:0]; then FXOR2 applies v1^=0xdd, FIN2 runs d rounds, and [127:64]=v0^v1^v2^v3.
- Completion: hash_valid=1, ready=1, return to IDLE. hash_word and hash_valid hold until the next init or reset.
- Sum arithmetic is mod 2^64. The length byte is total bytes mod 256.
- Empty message: send a single mi_last word with mi_bytes=0.

## Timing

- init to mi_ready=1: 2 cycles (LOAD, then WAIT).
- Per accepted block: 1 (accept/v3 xor) + ceil(c/R) + 1 (CEND) cycles. mi_ready is low throughout and re-asserts in the cycle after CEND.
- After the final CEND: 1 + ceil(d/R) cycles, plus 1 + ceil(d/R) more in long mode. hash_valid rises on the following edge.
- mi_ready is asserted only in WAIT. A word is accepted only when mi_valid and mi_ready are both high in the same cycle.
- init outside IDLE/WAIT is ignored. init in the same cycle as mi_valid in WAIT: init wins and the word is not accepted.
- reset_n low mid-operation returns every register to its reset value immediately.

## Configuration

- SIPHASH_LONG_EN defined: long mode, FXOR2 and FIN2 are present.
- SIPHASH_LONG_EN undefined: long input is ignored (treated as 0), FXOR2 and FIN2 are removed, and hash_word[127:64] is constant 0.

## Test plan

- Key k={64'h0f0e0d0c0b0a0908, 64'h0706050403020100}, c=2, d=4, long=0. Send mi=64'h0706050403020100, then mi=64'h000e0d0c0b0a0908 with mi_last and mi_bytes=7 -> hash_word[63:0]=64'ha129ca6149be45e5, hash_valid=1.
- Same key, c=2, d=4, empty message (mi_last, mi_bytes=0) -> 64'h726fdb47dd0e0e31.
- Same key, empty message, long=1 with SIPHASH_LONG_EN defined -> hash_word={64'h930255c71472f66d, 64'he6a825ba047f81a3}.
- 8-byte message with mi_bytes=8 -> PAD block {8'h08,56'h0} is processed. Result matches the software model, and mi_ready stays low until hash_valid.
- Run each of the above with ROUNDS_PER_CYCLE=2 and with c=3 -> tags identical to the R=1 run; measured latencies match the Timing formulas.
- Assert reset_n during FIN -> ready=1, hash_valid=0, mi_ready=0 next cycle. A new init then yields the correct tag.
